// File: rtl/synch_down_counter.sv
// Loadable down-counter/timer built from T-stages with a borrow chain; counts a loaded
// value to zero, then stops (one-shot) or reloads (auto-reload). bi/bo cascade units.
module synch_down_counter #(
    parameter int SIZE     = 4,
    parameter bit AUTO_RLD = 1'b0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic [SIZE-1:0] D,
    input  logic            en,
    input  logic            bi,
    input  logic            mode,
    output logic [SIZE-1:0] Q,
    output logic            tc,
    output logic            bo,
    output logic            done,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] q_q, q_d;
    logic [SIZE-1:0] rld_q, rld_d;
    logic            mode_q, mode_d;
    logic            done_q, done_d;

    logic            step;
    logic            zero;
    logic [SIZE-1:0] tog;
    logic [SIZE-1:0] q_dec;

    assign step = en & bi & (state_q == S_RUN);
    assign zero = (q_q == '0);

    // Stage i toggles when every lower stage is already zero (borrow ripples in parallel).
    assign tog[0] = step;
    generate
        for (genvar gi = 1; gi < SIZE; gi++) begin : g_stage
            assign tog[gi] = step & (q_q[gi-1:0] == '0);
        end
    endgenerate
    assign q_dec = q_q ^ tog;

    always_comb begin
        q_d     = q_q;
        rld_d   = rld_q;
        mode_d  = mode_q;
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            q_d     = D;
            rld_d   = D;
            mode_d  = mode;
            state_d = (D != '0) ? S_RUN : S_IDLE;
        end else if (step) begin
            if (zero) begin
                // Only reachable in auto-reload: the step after hitting zero restarts.
                if (mode_q) begin
                    q_d = rld_q;
                end else begin
                    state_d = S_DONE;
                end
            end else begin
                q_d = q_dec;
                if (q_q == SIZE'(1)) begin
                    done_d = 1'b1;
                    if (!mode_q) begin
                        state_d = S_DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            rld_q   <= '0;
            mode_q  <= AUTO_RLD;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rld_q   <= rld_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign tc   = zero & (state_q != S_IDLE);
    assign bo   = tc & en & bi;
    assign done = done_q;
    assign busy = (state_q == S_RUN);

endmodule
